fifo_sc_ram: RTL



---
 rtl/fifo_sc_ram.sv | 101 ++++++++++
 1 files changed

// File: rtl/fifo_sc_ram.sv
// Single-clock first-word-fall-through FIFO on an inferred dual-port RAM.
// Define FIFO_SC_ERR_EN to add the sticky ovf/unf error outputs.
module fifo_sc_ram #(
  parameter int DATAWIDTH    = 18,
  parameter int ADDRWIDTH    = 5,
  parameter int AFULL_LEVEL  = 28,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 we,
  output logic                 full,
  output logic                 afull,
  output logic [DATAWIDTH-1:0] rd_data,
  input  logic                 re,
  output logic                 ne,
  output logic                 aempty,
`ifdef FIFO_SC_ERR_EN
  output logic                 ovf,
  output logic                 unf,
`endif
  output logic [ADDRWIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] CAP = DEPTH[ADDRWIDTH:0];
  localparam logic [ADDRWIDTH:0] AF  = AFULL_LEVEL[ADDRWIDTH:0];
  localparam logic [ADDRWIDTH:0] AE  = AEMPTY_LEVEL[ADDRWIDTH:0];

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [ADDRWIDTH-1:0] wr_ptr;
  logic [ADDRWIDTH-1:0] rd_ptr;
  logic [ADDRWIDTH:0]   ram_cnt;
  logic [ADDRWIDTH:0]   cnt_nxt;
  logic                 push;
  logic                 pop;
  logic                 load;

  assign push = we && !full;
  assign pop  = re && ne;

  // Words still in the RAM, i.e. not yet in the output register.
  assign ram_cnt = count - {{ADDRWIDTH{1'b0}}, ne};
  // The refill only reads words that were written on an earlier edge, so
  // the read address never collides with this edge's write address.
  assign load    = (ram_cnt != '0) && (!ne || pop);
  assign cnt_nxt = count
                 + {{ADDRWIDTH{1'b0}}, push}
                 - {{ADDRWIDTH{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (reset_l && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      ne      <= 1'b0;
      count   <= '0;
      full    <= 1'b0;
      afull   <= 1'b0;
      aempty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      ne     <= load || (ne && !pop);
      count  <= cnt_nxt;
      full   <= (cnt_nxt == CAP);
      afull  <= (cnt_nxt >= AF);
      aempty <= (cnt_nxt <= AE);
    end
  end

`ifdef FIFO_SC_ERR_EN
  // A read issued together with a write into an empty FIFO is not an underflow.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (we && full) begin
        ovf <= 1'b1;
      end
      if (re && !ne && !we) begin
        unf <= 1'b1;
      end
    end
  end
`endif

endmodule
